lsu_bus_master: RTL and testbench
=================================

// Module: lsu_bus_master
// PURPOSE
//  Load/store unit at the consumer end of the decoder's d_wr_en/store_size/load_size/funct3 signals.
//  Turns one core memory request into one valid/ready bus transaction:
//   - byte-lane alignment on stores; extraction and sign/zero extension on loads.
//  Stalls the core until the transaction completes; flags misaligned or timed-out accesses.
//  Sits between the RV32I datapath (ALU result = address) and the data-memory bus.
// PARAMETERS
//  TIMEOUT_CYCLES  16  max cycles in REQ+RESP before abort; 0 = timeout disabled
// PORTS
//  clk            in   1   system clock
//  reset_n        in   1   asynchronous, active-low reset
//  ls_load        in   1   load request (IL-type)
//  ls_store       in   1   store request (d_wr_en)
//  addr           in   32  byte address
//  wdata          in   32  store data (rs2)
//  store_size     in   2   00 sb, 01 sh, 10 sw
//  load_size      in   2   00 lb, 01 lh/lhu, 10 lw, 11 lbu
//  funct3         in   3   funct3[2]=1 selects unsigned (lhu) when load_size=01
//  stall          out  1   hold PC/pipeline
//  done           out  1   one-cycle completion pulse
//  rdata          out  32  extended load result, valid while done=1
//  misalign_err   out  1   valid with done
//  timeout_err    out  1   valid with done
//  bus_valid      out  1   request valid
//  bus_we         out  1   1 = write
//  bus_addr       out  32  word-aligned address {addr[31:2],2'b00}
//  bus_wdata      out  32  lane-replicated store data
//  bus_be         out  4   byte enables
//  bus_ready      in   1   bus accepts request when bus_valid&bus_ready
//  bus_rvalid     in   1   read data valid
//  bus_rdata      in   32  read data word
// BEHAVIOUR
//  Reset: state=IDLE; every registered output and timeout counter = 0.
//   - Reset mid-transaction: bus_valid drops immediately; no done pulse.
//  FSM states: IDLE, REQ, RESP, DONE.
//  IDLE:
//   - ls_store|ls_load: latch addr, wdata, sizes, funct3 and type.
//   - Both asserted: store wins.
//   - Misaligned: go to DONE, misalign_err=1, no bus transaction.
//       halfword: addr[0]=1; word: addr[1:0]!=0.
//   - Otherwise go to REQ.
//  REQ:
//   - bus_valid=1; bus_we/addr/wdata/be held stable until bus_ready.
//   - On handshake: store -> DONE, load -> RESP.
//  RESP: wait for bus_rvalid (sampled only here, never in the handshake cycle), capture extracted rdata, then DONE.
//  DONE: done=1 for exactly one cycle, then IDLE; a new request may be accepted in the following IDLE cycle.
//  stall = (state==IDLE & (ls_load|ls_store)) | state==REQ | state==RESP; stall=0 in DONE.
//  Timeout: counter clears on leaving IDLE and increments in REQ and RESP.
//   - Reaching TIMEOUT_CYCLES: go to DONE, timeout_err=1, rdata=0, bus_valid drops.
//   - Error flags and rdata clear on return to IDLE.
//  Store lanes:
//   - sb: be = 4'b0001<<addr[1:0], wdata {4{wdata[7:0]}}
//   - sh: be = addr[1] ? 1100 : 0011, wdata {2{wdata[15:0]}}
//   - sw: be = 1111
//  Loads: bus_be=1111, bus_we=0.
//   - byte selected by addr[1:0]: lb sign-extends, lbu zero-extends.
//   - half selected by addr[1]: funct3[2]=0 sign-extends, 1 zero-extends.
//   - lw: word passed through unchanged.
//  Latency with zero-wait bus: store done at cycle 2, load done at cycle 3 after the request cycle.
// STRUCTURE
//  Package rv32i_lsu_pkg:
//   - lsu_state_t enum
//   - size encodings SZ_B=2'b00, SZ_H=2'b01, SZ_W=2'b10, SZ_BU=2'b11
//  Sub-module lsu_align (combinational):
//   - store lane and be generation
//   - load extraction and extension
//   - misalign detection
// TESTING
//  1 sb addr=0x1003 wdata=0x000000A5, bus_ready=1
//     -> bus_be=1000, bus_wdata=0xA5A5A5A5, bus_addr=0x1000, done at cycle 2.
//  2 lb addr=0x2002, bus_rdata=0x00800000
//     -> rdata=0xFFFFFF80; same with lbu -> 0x00000080.
//  3 lhu (load_size=01, funct3=101) addr=0x2002, bus_rdata=0xBEEF1234 -> rdata=0x0000BEEF;
//    lh -> 0xFFFFBEEF.
//  4 sw addr=0x3002 -> no bus_valid, done next cycle, misalign_err=1.
//  5 lw, bus_ready held 0, TIMEOUT_CYCLES=4
//     -> bus_valid high 4 cycles, then done with timeout_err=1, rdata=0.
//  6 reset_n low while in RESP -> bus_valid=0, stall=0, no done; next lw completes normally.

Source files
------------

// File: rtl/rv32i_lsu_pkg.sv
// Shared types and size encodings for the RV32I load/store unit.
package rv32i_lsu_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StResp,
    StDone
  } lsu_state_t;

  localparam logic [1:0] SZ_B  = 2'b00;
  localparam logic [1:0] SZ_H  = 2'b01;
  localparam logic [1:0] SZ_W  = 2'b10;
  localparam logic [1:0] SZ_BU = 2'b11;

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane steering for stores, load extraction/extension and
// misalignment detection on an incoming request.
module lsu_align
  import rv32i_lsu_pkg::*;
(
  // live request, checked before it is accepted
  input  logic        chk_store,
  input  logic [1:0]  chk_addr,
  input  logic [1:0]  chk_store_size,
  input  logic [1:0]  chk_load_size,
  output logic        misaligned,
  // latched transaction
  input  logic        is_store,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  store_size,
  input  logic [1:0]  load_size,
  input  logic        unsigned_half,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_word,
  output logic [3:0]  be,
  output logic [31:0] wdata_lanes,
  output logic [31:0] load_data
);

  logic [1:0]  chk_size;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    chk_size   = chk_store ? chk_store_size : chk_load_size;
    misaligned = ((chk_size == SZ_H) && chk_addr[0]) ||
                 ((chk_size == SZ_W) && (chk_addr != 2'b00));
  end

  always_comb begin
    be          = 4'b1111;
    wdata_lanes = wdata;
    if (is_store) begin
      unique case (store_size)
        SZ_H: begin
          be          = addr_lo[1] ? 4'b1100 : 4'b0011;
          wdata_lanes = {2{wdata[15:0]}};
        end
        SZ_W: begin
          be          = 4'b1111;
          wdata_lanes = wdata;
        end
        default: begin
          be          = 4'b0001 << addr_lo;
          wdata_lanes = {4{wdata[7:0]}};
        end
      endcase
    end
  end

  always_comb begin
    unique case (addr_lo)
      2'd0:    byte_sel = rdata_word[7:0];
      2'd1:    byte_sel = rdata_word[15:8];
      2'd2:    byte_sel = rdata_word[23:16];
      default: byte_sel = rdata_word[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata_word[31:16] : rdata_word[15:0];

    unique case (load_size)
      SZ_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      SZ_BU:   load_data = {24'h0, byte_sel};
      SZ_H:    load_data = unsigned_half ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_data = rdata_word;
    endcase
  end

endmodule

// File: rtl/lsu_bus_master.sv
// Load/store unit: turns one core memory request into one valid/ready bus
// transaction, stalling the core until it completes, errors, or times out.
module lsu_bus_master
  import rv32i_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ls_load,
  input  logic        ls_store,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  store_size,
  input  logic [1:0]  load_size,
  input  logic [2:0]  funct3,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic        misalign_err,
  output logic        timeout_err,
  output logic        bus_valid,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ready,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  lsu_state_t      state_q, state_d;
  logic [31:0]     addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [1:0]      ssize_q, ssize_d, lsize_q, lsize_d;
  logic            uns_q, uns_d, store_q, store_d, mis_q, mis_d, to_q, to_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            misaligned, timeout_hit;
  logic [31:0]     load_data;
  logic            unused_funct3;

  assign unused_funct3 = ^funct3[1:0];

  lsu_align u_align (
    .chk_store      (ls_store),
    .chk_addr       (addr[1:0]),
    .chk_store_size (store_size),
    .chk_load_size  (load_size),
    .misaligned     (misaligned),
    .is_store       (store_q),
    .addr_lo        (addr_q[1:0]),
    .store_size     (ssize_q),
    .load_size      (lsize_q),
    .unsigned_half  (uns_q),
    .wdata          (wdata_q),
    .rdata_word     (bus_rdata),
    .be             (bus_be),
    .wdata_lanes    (bus_wdata),
    .load_data      (load_data)
  );

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ssize_d = ssize_q;
    lsize_d = lsize_q;
    uns_d   = uns_q;
    store_d = store_q;
    rdata_d = rdata_q;
    mis_d   = mis_q;
    to_d    = to_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (ls_store || ls_load) begin
          addr_d  = addr;
          wdata_d = wdata;
          ssize_d = store_size;
          lsize_d = load_size;
          uns_d   = funct3[2];
          store_d = ls_store;
          if (misaligned) begin
            state_d = StDone;
            mis_d   = 1'b1;
          end else begin
            state_d = StReq;
          end
        end
      end
      StReq: begin
        cnt_d = cnt_q + CntW'(1);
        if (bus_ready) begin
          state_d = store_q ? StDone : StResp;
        end else if (timeout_hit) begin
          state_d = StDone;
          to_d    = 1'b1;
          rdata_d = '0;
        end
      end
      StResp: begin
        cnt_d = cnt_q + CntW'(1);
        if (bus_rvalid) begin
          state_d = StDone;
          rdata_d = load_data;
        end else if (timeout_hit) begin
          state_d = StDone;
          to_d    = 1'b1;
          rdata_d = '0;
        end
      end
      default: begin
        // results are only visible during the done pulse
        state_d = StIdle;
        rdata_d = '0;
        mis_d   = 1'b0;
        to_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wdata_q <= '0;
      ssize_q <= '0;
      lsize_q <= '0;
      uns_q   <= 1'b0;
      store_q <= 1'b0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
      to_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ssize_q <= ssize_d;
      lsize_q <= lsize_d;
      uns_q   <= uns_d;
      store_q <= store_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
      to_q    <= to_d;
      cnt_q   <= cnt_d;
    end
  end

  assign stall        = ((state_q == StIdle) && (ls_load || ls_store)) ||
                        (state_q == StReq) || (state_q == StResp);
  assign done         = (state_q == StDone);
  assign rdata        = rdata_q;
  assign misalign_err = mis_q;
  assign timeout_err  = to_q;
  assign bus_valid    = (state_q == StReq);
  assign bus_we       = store_q;
  assign bus_addr     = {addr_q[31:2], 2'b00};

endmodule

// File: tb/tb_lsu_bus_master.sv
// Scoreboard bench for lsu_bus_master: expected completions are queued when a
// request is driven and compared when the done pulse appears.
module tb_lsu_bus_master;

  localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10, BU = 2'b11;

  typedef struct packed {
    logic [31:0] rdata;
    logic        mis;
    logic        to;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ls_load, ls_store;
  logic [31:0] addr, wdata;
  logic [1:0]  store_size, load_size;
  logic [2:0]  funct3;
  logic        stall, done, misalign_err, timeout_err;
  logic [31:0] rdata;
  logic        bus_valid, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ready, bus_rvalid;
  logic [31:0] bus_rdata;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  lsu_bus_master #(.TIMEOUT_CYCLES(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .ls_load      (ls_load),
    .ls_store     (ls_store),
    .addr         (addr),
    .wdata        (wdata),
    .store_size   (store_size),
    .load_size    (load_size),
    .funct3       (funct3),
    .stall        (stall),
    .done         (done),
    .rdata        (rdata),
    .misalign_err (misalign_err),
    .timeout_err  (timeout_err),
    .bus_valid    (bus_valid),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_be       (bus_be),
    .bus_ready    (bus_ready),
    .bus_rvalid   (bus_rvalid),
    .bus_rdata    (bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One request from the core; cycle 0 is the request cycle.
  task automatic txn(input string name, input logic st, input logic ld, input logic [31:0] a,
                     input logic [31:0] wd, input logic [1:0] ssz, input logic [1:0] lsz,
                     input logic [2:0] f3, input logic [31:0] rword, input logic rdy,
                     input logic [31:0] exp_rd, input logic exp_mis, input logic exp_to,
                     input int exp_lat, input int exp_vcyc, input logic [3:0] exp_be,
                     input logic [31:0] exp_baddr, input logic [31:0] exp_wd);
    int   cyc = 0;
    int   vcyc = 0;
    logic got_done = 1'b0;
    exp_t e;
    @(negedge clk);
    ls_store = st; ls_load = ld; addr = a; wdata = wd;
    store_size = ssz; load_size = lsz; funct3 = f3;
    bus_rdata = rword; bus_ready = rdy; bus_rvalid = 1'b1;
    sb.push_back('{rdata: exp_rd, mis: exp_mis, to: exp_to});
    #1 check_eq({name, "_stall_req"}, 32'(stall), 32'd1);
    while (!got_done && cyc < 20) begin
      @(negedge clk);
      cyc++;
      ls_store = 1'b0; ls_load = 1'b0;
      if (bus_valid) begin
        if (vcyc == 0) begin
          check_eq({name, "_we"}, 32'(bus_we), 32'(st));
          check_eq({name, "_addr"}, bus_addr, exp_baddr);
          check_eq({name, "_be"}, 32'(bus_be), 32'(exp_be));
          if (st) check_eq({name, "_wdata"}, bus_wdata, exp_wd);
        end
        vcyc++;
      end
      if (done) begin
        got_done = 1'b1;
        check_eq({name, "_latency"}, cyc, exp_lat);
        check_eq({name, "_stall_done"}, 32'(stall), 32'd0);
        if (sb.size() == 0) begin
          check_eq({name, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
          e = sb.pop_front();
          check_eq({name, "_rdata"}, rdata, e.rdata);
          check_eq({name, "_mis"}, 32'(misalign_err), 32'(e.mis));
          check_eq({name, "_to"}, 32'(timeout_err), 32'(e.to));
        end
      end
    end
    if (!got_done) check_eq({name, "_done_seen"}, 32'd0, 32'd1);
    check_eq({name, "_valid_cycles"}, vcyc, exp_vcyc);
    @(negedge clk);
    check_eq({name, "_done_pulse"}, 32'(done), 32'd0);
    check_eq({name, "_flags_clr"}, {30'd0, misalign_err, timeout_err}, 32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    ls_load = 1'b0; ls_store = 1'b0; addr = '0; wdata = '0;
    store_size = '0; load_size = '0; funct3 = '0;
    bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_stall", 32'(stall), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_valid", 32'(bus_valid), 32'd0);
    check_eq("rst_rdata", rdata, 32'd0);
    check_eq("rst_errs", {30'd0, misalign_err, timeout_err}, 32'd0);
    reset_n = 1'b1;

    txn("sb", 1, 0, 32'h1003, 32'h000000A5, B, B, 3'b000, 32'h0, 1,
        32'h0, 0, 0, 2, 1, 4'b1000, 32'h1000, 32'hA5A5A5A5);
    txn("sh", 1, 0, 32'h5002, 32'h1234ABCD, H, B, 3'b001, 32'h0, 1,
        32'h0, 0, 0, 2, 1, 4'b1100, 32'h5000, 32'hABCDABCD);
    txn("both", 1, 1, 32'h8000, 32'h11223344, W, W, 3'b010, 32'h0, 1,
        32'h0, 0, 0, 2, 1, 4'b1111, 32'h8000, 32'h11223344);
    txn("lb", 0, 1, 32'h2002, 32'h0, B, B, 3'b000, 32'h00800000, 1,
        32'hFFFFFF80, 0, 0, 3, 1, 4'b1111, 32'h2000, 32'h0);
    txn("lbu", 0, 1, 32'h2002, 32'h0, B, BU, 3'b100, 32'h00800000, 1,
        32'h00000080, 0, 0, 3, 1, 4'b1111, 32'h2000, 32'h0);
    txn("lb1", 0, 1, 32'h9001, 32'h0, B, B, 3'b000, 32'h00007F00, 1,
        32'h0000007F, 0, 0, 3, 1, 4'b1111, 32'h9000, 32'h0);
    txn("lhu", 0, 1, 32'h2002, 32'h0, B, H, 3'b101, 32'hBEEF1234, 1,
        32'h0000BEEF, 0, 0, 3, 1, 4'b1111, 32'h2000, 32'h0);
    txn("lh", 0, 1, 32'h2002, 32'h0, B, H, 3'b001, 32'hBEEF1234, 1,
        32'hFFFFBEEF, 0, 0, 3, 1, 4'b1111, 32'h2000, 32'h0);
    txn("lw", 0, 1, 32'h6004, 32'h0, B, W, 3'b010, 32'hCAFEF00D, 1,
        32'hCAFEF00D, 0, 0, 3, 1, 4'b1111, 32'h6004, 32'h0);
    txn("sw_mis", 1, 0, 32'h3002, 32'hDEADBEEF, W, B, 3'b010, 32'h0, 1,
        32'h0, 1, 0, 1, 0, 4'b1111, 32'h3000, 32'h0);
    txn("lh_mis", 0, 1, 32'h7001, 32'h0, B, H, 3'b001, 32'h12345678, 1,
        32'h0, 1, 0, 1, 0, 4'b1111, 32'h7000, 32'h0);
    txn("lw_to", 0, 1, 32'h4000, 32'h0, B, W, 3'b010, 32'h55555555, 0,
        32'h0, 0, 1, 5, 4, 4'b1111, 32'h4000, 32'h0);

    // reset while waiting for read data
    @(negedge clk);
    ls_load = 1'b1; load_size = W; addr = 32'hA000; bus_ready = 1'b1; bus_rvalid = 1'b0;
    @(negedge clk);
    ls_load = 1'b0;
    check_eq("rst6_req_valid", 32'(bus_valid), 32'd1);
    @(negedge clk);
    check_eq("rst6_resp_stall", 32'(stall), 32'd1);
    reset_n = 1'b0;
    #1;
    check_eq("rst6_valid", 32'(bus_valid), 32'd0);
    check_eq("rst6_stall", 32'(stall), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("rst6_no_done", 32'(done), 32'd0);
    end
    reset_n = 1'b1;
    txn("lw_after_rst", 0, 1, 32'hA004, 32'h0, B, W, 3'b010, 32'h13579BDF, 1,
        32'h13579BDF, 0, 0, 3, 1, 4'b1111, 32'hA004, 32'h0);

    check_eq("sb_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
